// File: rtl/mainboard_wb_arbiter.sv
// ============================================================================
// mainboard_wb_arbiter
//
// Two-master Wishbone arbiter in front of the mainboard's byte-wide
// configuration/debug slave port (VDP, console ROM, GROM, cartridge ROM and
// speech ROM windows). Master 0 is the host debugger and master 1 is the
// ROM/GROM image loader.
//
// Ownership is granted per CYC frame, round-robin on ties. The owner's bus is
// passed combinationally to the slave, and the slave's ack/data come straight
// back, so no latency is added per access. A strobe the slave never
// acknowledges is aborted after timeout_cycles unacked cycles. The owner then
// receives a one-cycle err pulse, and its strobe is masked until it drops STB.
//
// Parameters
//   timeout_cycles  unacked strobed cycles before abort (1..65535)
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   m0_* / m1_*         master-side Wishbone ports (adr, dat in/out, we, sel,
//                       stb, cyc, ack, err)
//   s_*                 slave-side Wishbone port
//   grant               registered one-hot owner: 10 = master 0,
//                       01 = master 1, 00 = none
// ============================================================================
module mainboard_wb_arbiter #(
    parameter int unsigned timeout_cycles = 255
) (
    input  logic        clk,
    input  logic        reset_n,

    input  logic [0:23] m0_adr_i,
    input  logic [0:7]  m0_dat_i,
    output logic [0:7]  m0_dat_o,
    input  logic        m0_we_i,
    input  logic [0:0]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic        m0_ack_o,
    output logic        m0_err_o,

    input  logic [0:23] m1_adr_i,
    input  logic [0:7]  m1_dat_i,
    output logic [0:7]  m1_dat_o,
    input  logic        m1_we_i,
    input  logic [0:0]  m1_sel_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic        m1_ack_o,
    output logic        m1_err_o,

    output logic [0:23] s_adr_o,
    output logic [0:7]  s_dat_o,
    input  logic [0:7]  s_dat_i,
    output logic        s_we_o,
    output logic [0:0]  s_sel_o,
    output logic        s_stb_o,
    output logic        s_cyc_o,
    input  logic        s_ack_i,

    output logic [0:1]  grant
);

    localparam int CNT_W = (timeout_cycles < 1) ? 1 : $clog2(timeout_cycles + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(timeout_cycles);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_OWN0    = 2'd1,
        ST_OWN1    = 2'd2,
        ST_RELEASE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_last_grant;   // 0 = master 0 owned last, 1 = master 1
    logic [CNT_W-1:0] r_cnt;
    logic             r_abort;
    logic             r_err0;
    logic             r_err1;
    logic [0:1]       r_grant;

    logic             w_own0;
    logic             w_own1;
    logic             w_owner_stb;
    logic             w_stb;
    logic             w_timeout;
    logic             w_cnt_run;

    assign w_own0 = (r_state == ST_OWN0);
    assign w_own1 = (r_state == ST_OWN1);

    // Raw STB of whoever owns the bus; used to release the abort mask.
    assign w_owner_stb = (w_own0 & m0_stb_i) | (w_own1 & m1_stb_i);

    assign w_stb = ((w_own0 & m0_cyc_i & m0_stb_i) |
                    (w_own1 & m1_cyc_i & m1_stb_i)) & ~r_abort;

    // An ack arriving in the limit cycle wins: no timeout is flagged.
    assign w_timeout = w_stb & ~s_ack_i & (r_cnt == CNT_LIMIT);

    assign w_cnt_run = w_stb & ~s_ack_i & ~w_timeout & (w_state_nxt == r_state);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_state_nxt = r_last_grant ? ST_OWN0 : ST_OWN1;
                end else if (m0_cyc_i) begin
                    w_state_nxt = ST_OWN0;
                end else if (m1_cyc_i) begin
                    w_state_nxt = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc_i) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc_i) begin
                    w_state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Bus multiplexing: the owner's request goes to the slave, the slave's
    // response goes back to the owner only.
    // ------------------------------------------------------------------------
    always_comb begin
        s_adr_o  = '0;
        s_dat_o  = '0;
        s_we_o   = 1'b0;
        s_sel_o  = '0;
        s_cyc_o  = 1'b0;
        m0_dat_o = '0;
        m1_dat_o = '0;
        case (r_state)
            ST_OWN0: begin
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_cyc_o  = m0_cyc_i;
                m0_dat_o = s_dat_i;
            end
            ST_OWN1: begin
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_cyc_o  = m1_cyc_i;
                m1_dat_o = s_dat_i;
            end
            default: begin
            end
        endcase
    end

    assign s_stb_o  = w_stb;
    assign m0_ack_o = w_own0 & s_ack_i & w_stb;
    assign m1_ack_o = w_own1 & s_ack_i & w_stb;
    assign m0_err_o = r_err0 & w_own0;
    assign m1_err_o = r_err1 & w_own1;
    assign grant    = r_grant;

    // ------------------------------------------------------------------------
    // State, grant and round-robin history
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_grant      <= 2'b00;
            r_last_grant <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            case (w_state_nxt)
                ST_OWN0: r_grant <= 2'b10;
                ST_OWN1: r_grant <= 2'b01;
                default: r_grant <= 2'b00;
            endcase
            if (r_state == ST_IDLE && w_state_nxt == ST_OWN0) begin
                r_last_grant <= 1'b0;
            end else if (r_state == ST_IDLE && w_state_nxt == ST_OWN1) begin
                r_last_grant <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Timeout counter, abort mask and error pulse
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt   <= '0;
            r_abort <= 1'b0;
            r_err0  <= 1'b0;
            r_err1  <= 1'b0;
        end else begin
            if (w_cnt_run) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end else begin
                r_cnt <= '0;
            end

            // Error is a single registered pulse to the current owner.
            r_err0 <= w_timeout & w_own0;
            r_err1 <= w_timeout & w_own1;

            // Mask stays until the owner drops STB (or loses the bus).
            if (w_timeout) begin
                r_abort <= 1'b1;
            end else if (!w_owner_stb || (w_state_nxt != r_state)) begin
                r_abort <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mainboard_wb_arbiter.sv
module tb_mainboard_wb_arbiter;

    logic        clk;
    logic        reset_n;
    logic [0:23] m0_adr_i, m1_adr_i;
    logic [0:7]  m0_dat_i, m1_dat_i;
    logic [0:7]  m0_dat_o, m1_dat_o;
    logic        m0_we_i, m1_we_i;
    logic [0:0]  m0_sel_i, m1_sel_i;
    logic        m0_stb_i, m1_stb_i;
    logic        m0_cyc_i, m1_cyc_i;
    logic        m0_ack_o, m1_ack_o;
    logic        m0_err_o, m1_err_o;
    logic [0:23] s_adr_o;
    logic [0:7]  s_dat_o;
    logic [0:7]  s_dat_i;
    logic        s_we_o;
    logic [0:0]  s_sel_o;
    logic        s_stb_o;
    logic        s_cyc_o;
    logic        s_ack_i;
    logic [0:1]  grant;

    // Slave model: either acks every strobe at once, or follows man_ack.
    logic auto_ack;
    logic man_ack;
    assign s_ack_i = auto_ack ? s_stb_o : man_ack;

    int n_checks;
    int n_fail;
    int rr_timeouts;
    bit d0, d1;
    logic [0:1] order_q[$];
    int min_gap;

    mainboard_wb_arbiter #(.timeout_cycles(4)) dut (
        .clk(clk), .reset_n(reset_n),
        .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_we_i(m0_we_i), .m0_sel_i(m0_sel_i), .m0_stb_i(m0_stb_i),
        .m0_cyc_i(m0_cyc_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
        .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_we_i(m1_we_i), .m1_sel_i(m1_sel_i), .m1_stb_i(m1_stb_i),
        .m1_cyc_i(m1_cyc_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_we_o(s_we_o), .s_sel_o(s_sel_o), .s_stb_o(s_stb_o),
        .s_cyc_o(s_cyc_o), .s_ack_i(s_ack_i), .grant(grant)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for the given grant; leaves the bench at a negedge.
    task automatic wait_grant(input string tag, input logic [0:1] g);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (grant == g) seen = 1'b1;
        end
        check_val(tag, 32'(grant), 32'(g));
    endtask

    task automatic drop_all();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        man_ack  = 1'b0;
    endtask

    // One single-byte transaction for round-robin, acked by the slave model.
    task automatic rr_txn(input int id);
        bit got;
        next_cycle();
        if (id == 0) begin
            m0_cyc_i = 1'b1; m0_stb_i = 1'b1; m0_adr_i = 24'h000100;
        end else begin
            m1_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_adr_i = 24'h000200;
        end
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if ((id == 0 && m0_ack_o) || (id == 1 && m1_ack_o)) got = 1'b1;
        end
        if (!got) rr_timeouts++;
        next_cycle();
        if (id == 0) begin
            m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        end else begin
            m1_cyc_i = 1'b0; m1_stb_i = 1'b0;
        end
    endtask

    initial begin
        n_checks = 0; n_fail = 0; rr_timeouts = 0;
        auto_ack = 1'b1; man_ack = 1'b0; s_dat_i = 8'h00;
        m0_adr_i = 24'h111111; m0_dat_i = 8'h11; m0_we_i = 1'b1; m0_sel_i = 1'b1;
        m1_adr_i = 24'h222222; m1_dat_i = 8'h22; m1_we_i = 1'b1; m1_sel_i = 1'b1;
        m0_stb_i = 1'b1; m0_cyc_i = 1'b1; m1_stb_i = 1'b1; m1_cyc_i = 1'b1;
        reset_n = 1'b0;

        // Reset held with both masters requesting
        next_cycle();
        next_cycle();
        @(negedge clk);
        check_val("rst_grant", 32'(grant), 32'd0);
        check_val("rst_s_ctl", 32'({s_cyc_o, s_stb_o, s_we_o, s_sel_o}), 32'd0);
        check_val("rst_s_adr", 32'(s_adr_o), 32'd0);
        check_val("rst_s_dat", 32'(s_dat_o), 32'd0);
        check_val("rst_m_resp", 32'({m0_ack_o, m1_ack_o, m0_err_o, m1_err_o}), 32'd0);
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        check_val("rst_rel_grant0", 32'(grant), 32'd0);
        @(negedge clk);
        check_val("rst_rel_grant1", 32'(grant), 32'b10);
        check_val("rst_rel_adr", 32'(s_adr_o), 32'h111111);
        next_cycle();
        drop_all();
        repeat (3) next_cycle();

        // Single read by master 1, slave acks on the third strobe cycle
        auto_ack = 1'b0;
        m1_adr_i = 24'h010004; m1_we_i = 1'b0; m1_sel_i = 1'b1;
        m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        wait_grant("rd_grant", 2'b01);
        check_val("rd_s_adr", 32'(s_adr_o), 32'h010004);
        check_val("rd_s_stb", 32'(s_stb_o), 32'd1);
        check_val("rd_s_we", 32'(s_we_o), 32'd0);
        check_val("rd_ack_c0", 32'(m1_ack_o), 32'd0);
        @(negedge clk);
        check_val("rd_ack_c1", 32'(m1_ack_o), 32'd0);
        next_cycle();
        man_ack = 1'b1; s_dat_i = 8'hA5;
        @(negedge clk);
        check_val("rd_ack_c2", 32'(m1_ack_o), 32'd1);
        check_val("rd_dat", 32'(m1_dat_o), 32'hA5);
        check_val("rd_m0_ack", 32'(m0_ack_o), 32'd0);
        check_val("rd_m0_dat", 32'(m0_dat_o), 32'd0);
        next_cycle();
        drop_all();
        repeat (3) next_cycle();

        // Round-robin: three transactions per master, both contending
        auto_ack = 1'b1;
        d0 = 1'b0; d1 = 1'b0; min_gap = 1000;
        fork
            begin
                for (int k = 0; k < 3; k++) rr_txn(0);
                d0 = 1'b1;
            end
            begin
                for (int k = 0; k < 3; k++) rr_txn(1);
                d1 = 1'b1;
            end
            begin
                logic [0:1] prev_g;
                int gap;
                prev_g = 2'b00; gap = 0;
                for (int c = 0; c < 300 && !(d0 && d1); c++) begin
                    @(negedge clk);
                    if (grant != 2'b00 && prev_g == 2'b00) begin
                        if (order_q.size() > 0 && gap < min_gap) min_gap = gap;
                        order_q.push_back(grant);
                        gap = 0;
                    end else if (grant == 2'b00) begin
                        gap++;
                    end
                    prev_g = grant;
                end
            end
        join
        check_val("rr_timeouts", 32'(rr_timeouts), 32'd0);
        check_val("rr_count", 32'(order_q.size()), 32'd6);
        for (int k = 0; k < 6 && k < order_q.size(); k++) begin
            check_val($sformatf("rr_order%0d", k), 32'(order_q[k]),
                      (k % 2 == 0) ? 32'b10 : 32'b01);
        end
        check_val("rr_min_gap_ok", 32'(min_gap >= 2), 32'd1);
        repeat (3) next_cycle();

        // Burst hold: 16 strobes by master 0 while master 1 waits
        m0_adr_i = 24'h020000; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        m1_adr_i = 24'h030000; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        wait_grant("bu_grant", 2'b10);
        for (int i = 0; i < 16; i++) begin
            if (i > 0) begin
                next_cycle();
                m0_adr_i = 24'h020000 + 24'(i);
                @(negedge clk);
            end
            check_val($sformatf("bu_adr%0d", i), 32'(s_adr_o), 32'h020000 + 32'(i));
            check_val($sformatf("bu_ack%0d", i), 32'({m0_ack_o, m1_ack_o}), 32'b10);
            check_val($sformatf("bu_gnt%0d", i), 32'(grant), 32'b10);
        end
        next_cycle();
        m0_cyc_i = 1'b0; m0_stb_i = 1'b0;
        @(negedge clk);
        check_val("bu_drop_grant", 32'(grant), 32'b10);
        check_val("bu_drop_cyc", 32'(s_cyc_o), 32'd0);
        @(negedge clk);
        check_val("bu_rel_grant", 32'(grant), 32'd0);
        @(negedge clk);
        check_val("bu_idle_grant", 32'(grant), 32'd0);
        @(negedge clk);
        check_val("bu_m1_grant", 32'(grant), 32'b01);
        check_val("bu_m1_adr", 32'(s_adr_o), 32'h030000);
        next_cycle();
        drop_all();
        repeat (3) next_cycle();

        // Timeout: slave never acks, err 5 cycles after first strobe
        auto_ack = 1'b0; man_ack = 1'b0;
        m0_adr_i = 24'h040000; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        wait_grant("to_grant", 2'b10);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            check_val($sformatf("to_c%0d_stb", k), 32'(s_stb_o), 32'd1);
            check_val($sformatf("to_c%0d_err", k), 32'({m0_err_o, m0_ack_o}), 32'd0);
        end
        @(negedge clk);
        check_val("to_c5_err", 32'(m0_err_o), 32'd1);
        check_val("to_c5_stb", 32'(s_stb_o), 32'd0);
        check_val("to_c5_ack", 32'(m0_ack_o), 32'd0);
        @(negedge clk);
        check_val("to_c6_err", 32'(m0_err_o), 32'd0);
        check_val("to_c6_stb", 32'(s_stb_o), 32'd0);
        check_val("to_c6_grant", 32'(grant), 32'b10);
        next_cycle();
        m0_stb_i = 1'b0;
        next_cycle();
        m0_stb_i = 1'b1; man_ack = 1'b1; s_dat_i = 8'h3C;
        @(negedge clk);
        check_val("to_retry_ack", 32'(m0_ack_o), 32'd1);
        check_val("to_retry_dat", 32'(m0_dat_o), 32'h3C);
        check_val("to_retry_err", 32'(m0_err_o), 32'd0);
        next_cycle();
        drop_all();
        repeat (3) next_cycle();

        // Race: ack arrives in the cycle the counter hits the limit
        m0_adr_i = 24'h050000; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        wait_grant("race_grant", 2'b10);
        for (int k = 1; k < 4; k++) @(negedge clk);
        check_val("race_c3_err", 32'(m0_err_o), 32'd0);
        next_cycle();
        man_ack = 1'b1; s_dat_i = 8'h5A;
        @(negedge clk);
        check_val("race_c4_ack", 32'(m0_ack_o), 32'd1);
        check_val("race_c4_err", 32'(m0_err_o), 32'd0);
        next_cycle();
        man_ack = 1'b0; m0_stb_i = 1'b0;
        @(negedge clk);
        check_val("race_c5_err", 32'(m0_err_o), 32'd0);
        next_cycle();
        drop_all();
        repeat (3) next_cycle();

        // Asynchronous reset in the middle of a master 1 access
        m1_adr_i = 24'h060000; m1_cyc_i = 1'b1; m1_stb_i = 1'b1;
        wait_grant("ar_grant", 2'b01);
        check_val("ar_stb_before", 32'(s_stb_o), 32'd1);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("ar_stb_after", 32'(s_stb_o), 32'd0);
        check_val("ar_cyc_after", 32'(s_cyc_o), 32'd0);
        check_val("ar_grant_after", 32'(grant), 32'd0);
        m0_adr_i = 24'h070000; m0_cyc_i = 1'b1; m0_stb_i = 1'b1;
        next_cycle();
        reset_n = 1'b1;
        @(negedge clk);
        check_val("ar_rel_grant0", 32'(grant), 32'd0);
        @(negedge clk);
        check_val("ar_tie_grant", 32'(grant), 32'b10);
        next_cycle();
        drop_all();
        repeat (2) next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
